// File: rtl/audio_sdp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_sdp_scheduler_pkg
// Description : Shared symbol codes and state encoding for the audio SDP
//               scheduler and the audio packet inserter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_sdp_scheduler_pkg;

    // DP control symbols (9-bit, bit 8 = K flag)
    localparam logic [8:0] c_K_BS   = 9'h1BC;
    localparam logic [8:0] c_K_SS   = 9'h15C;
    localparam logic [8:0] c_K_SE   = 9'h1FD;

    // Markers stamped into lane0, first symbol, to select the packet type
    localparam logic [8:0] c_MK_AUD = 9'h155;
    localparam logic [8:0] c_MK_ATS = 9'h156;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_BS = 2'd1,
        ST_OFFSET  = 2'd2,
        ST_HOLD    = 2'd3
    } sched_state_t;

    function automatic logic is_bs(input logic [8:0] sym);
        return sym == c_K_BS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sdp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_sdp_scheduler_if
// Description : Main-link stream, control and status bundle of the audio SDP
//               scheduler. master = stream source / controller side,
//               slave = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_sdp_scheduler_if;

    logic        channel_ready;
    logic        source_ready;
    logic        audio_enable;
    logic        sample_strobe;
    logic [71:0] in_data;
    logic [71:0] out_data;
    logic        aud_issued;
    logic        ats_issued;
    logic [1:0]  sample_level;
    logic        overflow;

    modport master (
        output channel_ready, source_ready, audio_enable, sample_strobe, in_data,
        input  out_data, aud_issued, ats_issued, sample_level, overflow
    );

    modport slave (
        input  channel_ready, source_ready, audio_enable, sample_strobe, in_data,
        output out_data, aud_issued, ats_issued, sample_level, overflow
    );

endinterface
`default_nettype wire

// File: rtl/audio_sdp_scheduler_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sdp_scheduler_slot_timer
// Description : Shared offset/hold counter. A load restarts the count at 1
//               (BS seen or marker issued); run advances it. Terminal-count
//               flags report reaching the slot offset and the slot length.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sdp_scheduler_slot_timer #(
    parameter int SLOT_OFFSET = 8,
    parameter int SLOT_LEN    = 21
) (
    input  wire  clk,
    input  wire  rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_offset_tc,
    output logic o_hold_tc
);

    localparam int c_CNT_MAX = (SLOT_OFFSET > SLOT_LEN) ? SLOT_OFFSET : SLOT_LEN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Counter: load to 1 takes precedence over advancing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_CNT_W'(1);
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_offset_tc = (r_cnt == c_CNT_W'(SLOT_OFFSET));
    assign o_hold_tc   = (r_cnt == c_CNT_W'(SLOT_LEN));

endmodule
`default_nettype wire

// File: rtl/audio_sdp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : audio_sdp_scheduler
// Description : Schedules one secondary-data-packet slot per line on the DP
//               main link. Finds BS, waits a fixed offset, arbitrates between
//               audio-stream and audio-timestamp packets, and stamps a marker
//               into lane0 for the downstream packet inserter.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sdp_scheduler
    import audio_sdp_scheduler_pkg::*;
#(
    parameter int SLOT_OFFSET = 8,
    parameter int SLOT_LEN    = 21,
    parameter int TS_PERIOD   = 512
) (
    input wire                   clk,
    input wire                   rst,
    audio_sdp_scheduler_if.slave bus
);

    localparam int c_LINE_W = $clog2(TS_PERIOD);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [71:0]         r_out_data;
    logic                r_aud_issued;
    logic                r_ats_issued;
    logic [1:0]          r_level;
    logic                r_overflow;
    logic                r_ts_due;
    logic [c_LINE_W-1:0] r_line;

    logic                w_enable;
    logic                w_bs;
    logic                w_mk_ats;
    logic                w_mk_aud;
    logic                w_line_inc;
    logic                w_tmr_load;
    logic                w_tmr_run;
    logic                w_offset_tc;
    logic                w_hold_tc;
    logic [2:0]          w_level_sum;
    logic [1:0]          w_level_nxt;

    assign w_enable = bus.channel_ready & bus.source_ready & bus.audio_enable;
    assign w_bs     = is_bs(bus.in_data[8:0]);

    audio_sdp_scheduler_slot_timer #(
        .SLOT_OFFSET (SLOT_OFFSET),
        .SLOT_LEN    (SLOT_LEN)
    ) u_slot_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_tmr_load),
        .i_run       (w_tmr_run),
        .o_offset_tc (w_offset_tc),
        .o_hold_tc   (w_hold_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, slot arbitration and timer control; losing enable wins over everything
    always_comb begin
        w_state_nxt = r_state;
        w_mk_ats    = 1'b0;
        w_mk_aud    = 1'b0;
        w_line_inc  = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_run   = 1'b0;
        if (!w_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_BS;
                end
                ST_WAIT_BS: begin
                    if (w_bs) begin
                        w_state_nxt = ST_OFFSET;
                        w_tmr_load  = 1'b1;
                        w_line_inc  = 1'b1;
                    end
                end
                ST_OFFSET: begin
                    if (w_bs) begin
                        // A fresh BS restarts the offset, even on the would-be marker cycle
                        w_tmr_load = 1'b1;
                        w_line_inc = 1'b1;
                    end else if (w_offset_tc) begin
                        // Timestamp first, unless the sample buffer is full
                        if (r_ts_due && (r_level != 2'd3)) begin
                            w_mk_ats = 1'b1;
                        end else if (r_level >= 2'd2) begin
                            w_mk_aud = 1'b1;
                        end
                        if (w_mk_ats || w_mk_aud) begin
                            w_state_nxt = ST_HOLD;
                            w_tmr_load  = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT_BS;
                        end
                    end else begin
                        w_tmr_run = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_line_inc = w_bs;
                    if (w_hold_tc) begin
                        w_state_nxt = ST_WAIT_BS;
                    end else begin
                        w_tmr_run = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Pending-sample arithmetic with saturation at 3
    always_comb begin
        w_level_sum = {1'b0, r_level} + {2'b00, bus.sample_strobe};
        if (w_mk_aud) begin
            w_level_sum = w_level_sum - 3'd2;
        end
        w_level_nxt = w_level_sum[2] ? 2'd3 : w_level_sum[1:0];
    end

    // Stream delay with marker stamping, status pulses, level, line and timestamp tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_aud_issued <= 1'b0;
            r_ats_issued <= 1'b0;
            r_level      <= 2'd0;
            r_overflow   <= 1'b0;
            r_ts_due     <= 1'b0;
            r_line       <= '0;
        end else begin
            r_out_data <= bus.in_data;
            if (w_mk_ats) begin
                r_out_data[8:0] <= c_MK_ATS;
            end else if (w_mk_aud) begin
                r_out_data[8:0] <= c_MK_AUD;
            end
            r_aud_issued <= w_mk_aud;
            r_ats_issued <= w_mk_ats;
            if (bus.sample_strobe && (r_level == 2'd3) && !w_mk_aud) begin
                r_overflow <= 1'b1;
            end
            if (!w_enable) begin
                r_level  <= 2'd0;
                r_ts_due <= 1'b0;
                r_line   <= '0;
            end else begin
                r_level <= w_level_nxt;
                if (w_mk_ats) begin
                    r_ts_due <= 1'b0;
                end
                if (w_line_inc) begin
                    if (r_line == c_LINE_W'(TS_PERIOD - 1)) begin
                        r_line   <= '0;
                        r_ts_due <= 1'b1;
                    end else begin
                        r_line <= r_line + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.out_data     = r_out_data;
    assign bus.aud_issued   = r_aud_issued;
    assign bus.ats_issued   = r_ats_issued;
    assign bus.sample_level = r_level;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_sdp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_sdp_scheduler
// Description : Randomized bench for audio_sdp_scheduler. The driver issues
//               per-cycle stimulus and pushes the reference model's expected
//               outputs into a queue; the monitor pops and compares after
//               every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sdp_scheduler;

    localparam int         c_SLOT_OFFSET = 8;
    localparam int         c_SLOT_LEN    = 21;
    localparam int         c_TS_PERIOD   = 4;
    localparam int         c_NCYC        = 4000;
    localparam logic [8:0] c_BS          = 9'h1BC;
    localparam logic [8:0] c_AUD         = 9'h155;
    localparam logic [8:0] c_ATS         = 9'h156;

    typedef struct {
        logic [71:0] data;
        logic        aud;
        logic        ats;
        logic [1:0]  lvl;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_compared  = 0;
    int   n_mismatched = 0;
    int   n_aud_seen  = 0;
    int   n_ats_seen  = 0;

    audio_sdp_scheduler_if bus ();

    audio_sdp_scheduler #(
        .SLOT_OFFSET (c_SLOT_OFFSET),
        .SLOT_LEN    (c_SLOT_LEN),
        .TS_PERIOD   (c_TS_PERIOD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time-stamped view of the link (absolute cycle numbers)
    bit active;          // a cycle with enable has already passed since the last drop
    bit armed;           // BS seen, marker slot pending
    int marker_at;       // cycle index of the pending slot
    int busy_until;      // last cycle owned by the inserter
    int level;
    bit ts_due;
    int lines;
    bit ovf;

    function automatic void model_clear();
        active     = 1'b0;
        armed      = 1'b0;
        busy_until = -1;
    endfunction

    function automatic void count_line();
        lines = (lines + 1) % c_TS_PERIOD;
        if (lines == 0) ts_due = 1'b1;
    endfunction

    function automatic exp_t model_step(int c, logic r, logic en, logic strobe, logic [71:0] d);
        exp_t e;
        bit   bs;
        bit   mk_aud;
        bit   mk_ats;
        int   nl;
        mk_aud = 1'b0;
        mk_ats = 1'b0;
        e.data = d;
        if (r) begin
            model_clear();
            level  = 0;
            ts_due = 1'b0;
            lines  = 0;
            ovf    = 1'b0;
            e.data = '0;
            e.aud  = 1'b0;
            e.ats  = 1'b0;
            e.lvl  = 2'd0;
            e.ovf  = 1'b0;
            return e;
        end
        bs = (d[8:0] == c_BS);
        if (!en) begin
            model_clear();
        end else if (!active) begin
            active = 1'b1;
        end else if (c <= busy_until) begin
            if (bs) count_line();
        end else if (bs) begin
            count_line();
            armed     = 1'b1;
            marker_at = c + c_SLOT_OFFSET;
        end else if (armed && c == marker_at) begin
            armed = 1'b0;
            if (ts_due && level != 3) mk_ats = 1'b1;
            else if (level >= 2)      mk_aud = 1'b1;
            if (mk_ats || mk_aud) busy_until = c + c_SLOT_LEN;
        end
        if (strobe && level == 3 && !mk_aud) ovf = 1'b1;
        if (!en) begin
            level  = 0;
            ts_due = 1'b0;
            lines  = 0;
        end else begin
            if (mk_ats) ts_due = 1'b0;
            nl    = level + int'(strobe) - (mk_aud ? 2 : 0);
            level = (nl > 3) ? 3 : nl;
        end
        if (mk_ats)      e.data[8:0] = c_ATS;
        else if (mk_aud) e.data[8:0] = c_AUD;
        e.aud = mk_aud;
        e.ats = mk_ats;
        e.lvl = 2'(level);
        e.ovf = ovf;
        return e;
    endfunction

    // Driver: per-cycle random stimulus, expected response queued
    initial begin
        logic [95:0] rnd;
        logic [71:0] d;
        int          line_len;
        int          pos;
        int          strobe_pct;
        int          drop_left;
        int          drop_sel;
        line_len   = 20;
        pos        = 0;
        strobe_pct = 40;
        drop_left  = 0;
        drop_sel   = 0;
        for (int c = 0; c < c_NCYC; c++) begin
            if (c > 0) @(negedge clk);
            rnd = {$urandom(), $urandom(), $urandom()};
            d   = rnd[71:0];
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0:       strobe_pct = 0;
                    1:       strobe_pct = 10;
                    2:       strobe_pct = 35;
                    default: strobe_pct = 75;
                endcase
            end
            if (pos == 0 || $urandom_range(0, 99) < 2) d[8:0] = c_BS;
            pos = pos + 1;
            if (pos >= line_len) begin
                pos      = 0;
                line_len = $urandom_range(10, 50);
            end
            if (drop_left == 0 && c > 12 && $urandom_range(0, 999) < 5) begin
                drop_left = $urandom_range(1, 5);
                drop_sel  = $urandom_range(0, 2);
            end
            rst                   = (c < 3);
            bus.in_data           = d;
            bus.sample_strobe     = ($urandom_range(0, 99) < strobe_pct);
            bus.channel_ready     = !(c >= 3 && c < 8) && !(drop_left > 0 && drop_sel == 0);
            bus.source_ready      = !(drop_left > 0 && drop_sel == 1);
            bus.audio_enable      = !(drop_left > 0 && drop_sel == 2);
            if (drop_left > 0) drop_left = drop_left - 1;
            exp_q.push_back(model_step(c, rst, bus.channel_ready & bus.source_ready & bus.audio_enable,
                                       bus.sample_strobe, d));
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            n_mismatched = n_mismatched + 1;
        end
        if (n_aud_seen == 0 || n_ats_seen == 0) begin
            $display("FAIL coverage: aud=%0d ats=%0d markers observed, required both nonzero",
                     n_aud_seen, n_ats_seen);
            n_mismatched = n_mismatched + 1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Monitor: one expected entry per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow: queue empty at t=%0t, required an entry", $time);
                n_mismatched = n_mismatched + 1;
            end else begin
                e = exp_q.pop_front();
                n_compared = n_compared + 1;
                if (bus.aud_issued) n_aud_seen = n_aud_seen + 1;
                if (bus.ats_issued) n_ats_seen = n_ats_seen + 1;
                if (bus.out_data !== e.data || bus.aud_issued !== e.aud || bus.ats_issued !== e.ats ||
                    bus.sample_level !== e.lvl || bus.overflow !== e.ovf) begin
                    n_mismatched = n_mismatched + 1;
                    $display("FAIL cycle t=%0t: got data=%h aud=%b ats=%b lvl=%0d ovf=%b, required data=%h aud=%b ats=%b lvl=%0d ovf=%b",
                             $time, bus.out_data, bus.aud_issued, bus.ats_issued, bus.sample_level,
                             bus.overflow, e.data, e.aud, e.ats, e.lvl, e.ovf);
                end
            end
        end
    end

endmodule
`default_nettype wire
